shift_add_mult: RTL and testbench

- Sequential unsigned N_BIT x N_BIT multiplier built on the team's existing carry_ahead_add.
- Sits directly downstream of the adder: each cycle it consumes the adder's sum and carry-out and feeds the partial product back into it.
- Radix-2 shift-and-add: one multiplier bit per cycle, with a start/ready/done handshake toward the requesting datapath.

---
 rtl/mult_pkg.sv | 12 +
 rtl/carry_ahead_add.sv | 31 +++
 rtl/shift_add_mult.sv | 93 +++++++++
 tb/tb_shift_add_mult.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier: FSM state encoding and default width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

    localparam int DEFAULT_N_BIT = 16;

endpackage

// File: rtl/carry_ahead_add.sv
// Unsigned N_BIT adder built from per-bit generate/propagate terms with a
// lookahead carry recurrence; purely combinational.
module carry_ahead_add #(
    parameter int N_BIT = 16
) (
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic             cin,
    output logic [N_BIT-1:0] s,
    output logic             cout
);

    logic [N_BIT-1:0] g;
    logic [N_BIT-1:0] p;
    logic [N_BIT:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < N_BIT; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s    = p ^ c[N_BIT-1:0];
    assign cout = c[N_BIT];

endmodule

// File: rtl/shift_add_mult.sv
// Radix-2 sequential unsigned multiplier: one multiplier bit per cycle, with the
// partial product fed through a single carry_ahead_add and shifted right.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int N_BIT = DEFAULT_N_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_BIT-1:0]     a,
    input  logic [N_BIT-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*N_BIT-1:0]   product
);

    localparam int CW = $clog2(N_BIT + 1);

    mult_state_t          state_q, state_d;
    logic [N_BIT-1:0]     mcand_q, mcand_d;
    logic [2*N_BIT:0]     p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*N_BIT-1:0]   product_q, product_d;

    logic [N_BIT-1:0]     sum;
    logic                 cout;
    logic [N_BIT:0]       hi;

    carry_ahead_add #(.N_BIT(N_BIT)) u_add (
        .a    (p_q[2*N_BIT-1:N_BIT]),
        .b    (mcand_q),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Upper half plus carry; p_q[2*N_BIT] is always 0 between shifts.
    assign hi = p_q[0] ? {cout, sum} : p_q[2*N_BIT:N_BIT];

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mcand_d = a;
                    p_d     = {1'b0, {N_BIT{1'b0}}, b};
                    cnt_d   = '0;
                end
            end
            RUN: begin
                p_d   = {1'b0, hi, p_q[N_BIT-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_BIT - 1)) begin
                    state_d   = DONE;
                    product_d = p_d[2*N_BIT-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks of shift_add_mult at N_BIT=16 and N_BIT=8.
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start8;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        ready16, done16, ready8, done8;
    logic [31:0] product16;
    logic [15:0] product8;

    int n_vec = 0;
    int n_bad = 0;
    int done8_cnt = 0;
    int starts8 = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.N_BIT(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .ready(ready16), .done(done16), .product(product16)
    );

    shift_add_mult #(.N_BIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .product(product8)
    );

    always @(posedge clk) begin
        if (done8) done8_cnt <= done8_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One operation on the 16-bit unit: latency, ready low, product held, result, single pulse.
    task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp, input string tag);
        int          cyc;
        bit          rdy_low;
        bit          held;
        logic [31:0] prev;
        @(negedge clk);
        prev = product16;
        a16 = av; b16 = bv; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        rdy_low = !ready16;
        held = (product16 === prev);
        while (!done16 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ready16) rdy_low = 1'b0;
            if (!done16 && product16 !== prev) held = 1'b0;
        end
        chk({tag, "_lat"},  64'(cyc), 64'd17);
        chk({tag, "_rdy"},  64'(rdy_low), 64'd1);
        chk({tag, "_hold"}, 64'(held), 64'd1);
        chk({tag, "_prod"}, 64'(product16), 64'(exp));
        @(negedge clk);
        chk({tag, "_after"}, 64'({ready16, done16}), 64'b10);
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        starts8++;
        cyc = 1;
        while (!done8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc != 9) chk({tag, "_lat"}, 64'(cyc), 64'd9);
        chk({tag, "_prod"}, 64'(product8), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        int          pulses;
        int          last;
        int          cyc;
        int          dcnt;
        logic [15:0] ra, rb;
        logic [7:0]  sa, sb;

        rst = 1'b1;
        start16 = 1'b0; start8 = 1'b0;
        a16 = '0; b16 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready16), 64'd1);
        chk("rst_done",  64'(done16), 64'd0);
        chk("rst_prod",  64'(product16), 64'd0);
        chk("rst_prod8", 64'(product8), 64'd0);
        rst = 1'b0;

        run16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ones");
        run16(16'h000F, 16'h000F, 32'h000000E1, "f_f");
        run16(16'h0000, 16'h1234, 32'h00000000, "zero_a");
        run16(16'h8000, 16'h0002, 32'h00010000, "top_bit");
        run16(16'h1234, 16'h0000, 32'h00000000, "zero_b");

        // start held high; operands disturbed during the first RUN.
        @(negedge clk);
        a16 = 16'd3; b16 = 16'd5; start16 = 1'b1;
        @(negedge clk);
        a16 = 16'd7; b16 = 16'd7;
        pulses = 0; last = -1; cyc = 0;
        while (pulses < 3 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done16) begin
                chk("held_prod", 64'(product16), 64'd15);
                if (last >= 0) chk("held_space", 64'(cyc - last), 64'd18);
                last = cyc;
                pulses++;
                a16 = 16'd3; b16 = 16'd5;
            end
        end
        start16 = 1'b0;
        chk("held_pulses", 64'(pulses), 64'd3);
        @(negedge clk);
        chk("held_idle", 64'(ready16), 64'd1);

        // Reset during RUN cycle 8.
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h5678; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", 64'(ready16), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_ready", 64'(ready16), 64'd1);
        chk("mid_done",  64'(done16), 64'd0);
        chk("mid_prod",  64'(product16), 64'd0);
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done16) dcnt++;
        end
        chk("mid_nodone", 64'(dcnt), 64'd0);
        run16(16'h1234, 16'h5678, 32'h06260060, "restart");

        run16(16'd7, 16'd9, 32'd63, "hold_a");
        run16(16'd2, 16'd2, 32'd4, "hold_b");

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run16(ra, rb, {16'b0, ra} * {16'b0, rb}, "rnd16");
        end

        run8(8'hFF, 8'hFF, 16'hFE01, "ones8");
        run8(8'h00, 8'hA5, 16'h0000, "zero8");
        run8(8'h80, 8'h80, 16'h4000, "top8");
        for (int i = 0; i < 1000; i++) begin
            sa = 8'($urandom);
            sb = 8'($urandom);
            run8(sa, sb, {8'b0, sa} * {8'b0, sb}, "rnd8");
        end
        @(negedge clk);
        chk("done8_count", 64'(done8_cnt), 64'(starts8));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
